// File: rtl/vec_cmp_pkg.sv
// Shared types and helpers for the vector mask compare unit.
package vec_cmp_pkg;

    typedef enum logic [2:0] {
        CMP_EQ  = 3'b000,
        CMP_NE  = 3'b001,
        CMP_LTU = 3'b010,
        CMP_LEU = 3'b011,
        CMP_LT  = 3'b100,
        CMP_LE  = 3'b101,
        CMP_GT  = 3'b110,
        CMP_GTU = 3'b111
    } cmp_op_e;

    typedef enum logic [1:0] {
        SEW_8  = 2'b00,
        SEW_16 = 2'b01,
        SEW_32 = 2'b10,
        SEW_64 = 2'b11
    } sew_e;

    typedef enum logic {
        OPND_VV = 1'b0,
        OPND_VX = 1'b1
    } opnd_sel_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } cmp_state_e;

    function automatic int sew_bits(input sew_e s);
        return 8 << int'(s);
    endfunction

endpackage

// File: rtl/vec_cmp_slice.sv
// Combinational compare of one DP_W-bit chunk; result bit j belongs to element j of the chunk.
module vec_cmp_slice
    import vec_cmp_pkg::*;
#(
    parameter int DP_W = 256
) (
    input  logic [DP_W-1:0]   a,
    input  logic [DP_W-1:0]   b,
    input  cmp_op_e           op,
    input  sew_e              sew,
    output logic [DP_W/8-1:0] res
);

    // Widen an element to 65 bits so signed and unsigned ops share one signed compare.
    function automatic logic [64:0] extend(input logic [63:0] v, input int w, input logic sgn);
        logic [64:0] r;
        r = {1'b0, v};
        for (int k = 8; k < 65; k++) begin
            if (k >= w) r[k] = sgn & v[6'(w - 1)];
        end
        return r;
    endfunction

    function automatic logic cmp1(input logic [63:0] x, input logic [63:0] y,
                                  input int w, input cmp_op_e o);
        logic sgn;
        logic signed [64:0] xs, ys;
        sgn = (o == CMP_LT) || (o == CMP_LE) || (o == CMP_GT);
        xs  = extend(x, w, sgn);
        ys  = extend(y, w, sgn);
        case (o)
            CMP_EQ:          return xs == ys;
            CMP_NE:          return xs != ys;
            CMP_LTU, CMP_LT: return xs < ys;
            CMP_LEU, CMP_LE: return xs <= ys;
            default:         return xs > ys;
        endcase
    endfunction

    always_comb begin
        res = '0;
        case (sew)
            SEW_8:
                for (int j = 0; j < DP_W / 8; j++)
                    res[j] = cmp1(64'(a[j*8 +: 8]), 64'(b[j*8 +: 8]), 8, op);
            SEW_16:
                for (int j = 0; j < DP_W / 16; j++)
                    res[j] = cmp1(64'(a[j*16 +: 16]), 64'(b[j*16 +: 16]), 16, op);
            SEW_32:
                for (int j = 0; j < DP_W / 32; j++)
                    res[j] = cmp1(64'(a[j*32 +: 32]), 64'(b[j*32 +: 32]), 32, op);
            default:
                for (int j = 0; j < DP_W / 64; j++)
                    res[j] = cmp1(a[j*64 +: 64], b[j*64 +: 64], 64, op);
        endcase
    end

endmodule

// File: rtl/vec_mask_compare_unit.sv
// Multi-cycle vector integer compare producing an RVV packed mask, DP_W bits per beat.
module vec_mask_compare_unit
    import vec_cmp_pkg::*;
#(
    parameter int VLEN = 4096,
    parameter int ELEN = 32,
    parameter int DP_W = 256,
    parameter int MAXE = VLEN / 8,
    localparam int VL_W = $clog2(MAXE) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            ready,
    input  logic [2:0]      cmp_op,
    input  logic [1:0]      sew,
    input  logic            opnd_sel,
    input  logic [VLEN-1:0] vs2_data,
    input  logic [VLEN-1:0] vs1_data,
    input  logic [ELEN-1:0] scalar,
    input  logic            vm,
    input  logic [MAXE-1:0] v0_mask,
    input  logic [MAXE-1:0] vd_old,
    input  logic [VL_W-1:0] vl,
    output logic [MAXE-1:0] mask_result,
    output logic            done,
    output logic            error,
    output cmp_state_e      fsm_state
);
    localparam int BEAT_W  = $clog2(VLEN / 8) + 1;
    localparam int IDX_W   = $clog2(VLEN);
    localparam int EIX_W   = $clog2(MAXE);
    localparam int SLICE_E = DP_W / 8;

    // Handshake: start is taken only in a cycle where ready=1 (IDLE); done pulses for one
    // cycle with mask_result/error valid, and ready rises the cycle after done.

    cmp_state_e         state_q, state_d;
    logic [BEAT_W-1:0]  beat_q;
    cmp_op_e            op_q;
    sew_e               sew_q;
    logic [VLEN-1:0]    vs2_q, rhs_q;
    logic [MAXE-1:0]    en_q, en_d, mask_q, mask_d;
    logic [VL_W-1:0]    vl_q;
    logic               err_q, accept, start_err, last_beat;
    logic [SLICE_E-1:0] slice_res;
    logic [IDX_W-1:0]   chunk_lo;
    int                 epb, beat_base;

    function automatic logic [VLEN-1:0] broadcast(input logic [63:0] s, input sew_e w);
        logic [VLEN-1:0] r;
        case (w)
            SEW_8:   r = {(VLEN / 8){s[7:0]}};
            SEW_16:  r = {(VLEN / 16){s[15:0]}};
            SEW_32:  r = {(VLEN / 32){s[31:0]}};
            default: r = {(VLEN / 64){s}};
        endcase
        return r;
    endfunction

    assign accept    = start && (state_q == IDLE);
    assign start_err = (sew_bits(sew_e'(sew)) > ELEN) ||
                       (int'(vl) > VLEN / sew_bits(sew_e'(sew)));
    assign epb       = DP_W / sew_bits(sew_q);
    assign beat_base = int'(beat_q) * epb;
    assign last_beat = (beat_base + epb) >= int'(vl_q);
    assign chunk_lo  = IDX_W'(int'(beat_q) * DP_W);

    vec_cmp_slice #(.DP_W(DP_W)) u_slice (
        .a   (vs2_q[chunk_lo +: DP_W]),
        .b   (rhs_q[chunk_lo +: DP_W]),
        .op  (op_q),
        .sew (sew_q),
        .res (slice_res)
    );

    // Tail and v0 gating folded into one enable vector at accept time.
    always_comb begin
        en_d = '0;
        for (int i = 0; i < MAXE; i++)
            en_d[i] = (i < int'(vl)) && (vm || v0_mask[i]);
    end

    always_comb begin
        mask_d = mask_q;
        for (int j = 0; j < SLICE_E; j++) begin
            if (j < epb && (beat_base + j) < MAXE && en_q[EIX_W'(beat_base + j)])
                mask_d[EIX_W'(beat_base + j)] = slice_res[j];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (start_err || vl == '0) ? DONE : RUN;
            RUN:     if (last_beat) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_q <= '0;
            op_q   <= CMP_EQ;
            sew_q  <= SEW_8;
            vs2_q  <= '0;
            rhs_q  <= '0;
            en_q   <= '0;
            vl_q   <= '0;
            mask_q <= '0;
            err_q  <= 1'b0;
        end else if (accept) begin
            beat_q <= '0;
            op_q   <= cmp_op_e'(cmp_op);
            sew_q  <= sew_e'(sew);
            vs2_q  <= vs2_data;
            rhs_q  <= opnd_sel ? broadcast(64'(scalar), sew_e'(sew)) : vs1_data;
            en_q   <= en_d;
            vl_q   <= vl;
            mask_q <= vd_old;
            err_q  <= start_err;
        end else if (state_q == RUN) begin
            mask_q <= mask_d;
            beat_q <= beat_q + 1'b1;
        end
    end

    assign ready       = (state_q == IDLE);
    assign done        = (state_q == DONE);
    assign error       = err_q;
    assign mask_result = mask_q;
    assign fsm_state   = state_q;

endmodule

// File: tb/tb_vec_mask_compare_unit.sv
// Directed and random checks of vec_mask_compare_unit against a per-element reference model.
module tb_vec_mask_compare_unit;
    import vec_cmp_pkg::*;

    localparam int VLEN = 4096;
    localparam int ELEN = 32;
    localparam int DP_W = 256;
    localparam int MAXE = VLEN / 8;
    localparam int VL_W = $clog2(MAXE) + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            start = 1'b0;
    logic            ready;
    logic [2:0]      cmp_op = '0;
    logic [1:0]      sew = '0;
    logic            opnd_sel = 1'b0;
    logic [VLEN-1:0] vs2_data = '0;
    logic [VLEN-1:0] vs1_data = '0;
    logic [ELEN-1:0] scalar = '0;
    logic            vm = 1'b1;
    logic [MAXE-1:0] v0_mask = '0;
    logic [MAXE-1:0] vd_old = '0;
    logic [VL_W-1:0] vl = '0;
    logic [MAXE-1:0] mask_result;
    logic            done;
    logic            error;
    cmp_state_e      fsm_state;

    vec_mask_compare_unit #(.VLEN(VLEN), .ELEN(ELEN), .DP_W(DP_W)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .start       (start),
        .ready       (ready),
        .cmp_op      (cmp_op),
        .sew         (sew),
        .opnd_sel    (opnd_sel),
        .vs2_data    (vs2_data),
        .vs1_data    (vs1_data),
        .scalar      (scalar),
        .vm          (vm),
        .v0_mask     (v0_mask),
        .vd_old      (vd_old),
        .vl          (vl),
        .mask_result (mask_result),
        .done        (done),
        .error       (error),
        .fsm_state   (fsm_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [MAXE-1:0] exp_q[$];
    logic [MAXE-1:0] last_mask = '0;

    logic [2:0]      t_op;
    logic [1:0]      t_sew;
    logic            t_opnd;
    logic [VLEN-1:0] t_vs2, t_vs1;
    logic [ELEN-1:0] t_scalar;
    logic            t_vm;
    logic [MAXE-1:0] t_v0, t_vd_old;
    logic [VL_W-1:0] t_vl;

    task automatic check(input string tag, input logic [MAXE-1:0] obs, input logic [MAXE-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sx(input logic [63:0] v, input int w);
        logic [63:0] t;
        t = v << (64 - w);
        return $signed(t) >>> (64 - w);
    endfunction

    // Reference: evaluate each element straight from the operation rules.
    function automatic void model(output logic [MAXE-1:0] m, output logic e, output int lat);
        int w, epb;
        logic [63:0] mk, a, b;
        logic [VLEN-1:0] sh;
        logic r;
        w   = 8 << t_sew;
        mk  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        e   = (w > ELEN) || (int'(t_vl) > VLEN / w);
        m   = t_vd_old;
        lat = 1;
        if (e || t_vl == '0) return;
        epb = DP_W / w;
        lat = 1 + (int'(t_vl) + epb - 1) / epb;
        for (int i = 0; i < int'(t_vl); i++) begin
            if (!(t_vm || t_v0[i])) continue;
            sh = t_vs2 >> (i * w);
            a  = sh[63:0] & mk;
            if (t_opnd) b = 64'(t_scalar) & mk;
            else begin
                sh = t_vs1 >> (i * w);
                b  = sh[63:0] & mk;
            end
            case (t_op)
                3'd0:    r = (a == b);
                3'd1:    r = (a != b);
                3'd2:    r = (a < b);
                3'd3:    r = (a <= b);
                3'd4:    r = (sx(a, w) < sx(b, w));
                3'd5:    r = (sx(a, w) <= sx(b, w));
                3'd6:    r = (sx(a, w) > sx(b, w));
                default: r = (a > b);
            endcase
            m[i] = r;
        end
    endfunction

    function automatic logic [VLEN-1:0] rand_vec();
        logic [VLEN-1:0] v;
        for (int i = 0; i < VLEN / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [MAXE-1:0] rand_mask();
        logic [MAXE-1:0] v;
        for (int i = 0; i < MAXE / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic apply_inputs();
        cmp_op = t_op; sew = t_sew; opnd_sel = t_opnd; vs2_data = t_vs2; vs1_data = t_vs1;
        scalar = t_scalar; vm = t_vm; v0_mask = t_v0; vd_old = t_vd_old; vl = t_vl;
    endtask

    task automatic scramble_inputs();
        cmp_op = 3'($urandom); sew = 2'($urandom); opnd_sel = ~opnd_sel; vs2_data = ~vs2_data;
        vs1_data = rand_vec(); scalar = ~scalar; vm = ~vm; v0_mask = ~v0_mask;
        vd_old = ~vd_old; vl = VL_W'($urandom_range(0, MAXE));
    endtask

    // ---------------- driver ----------------
    task automatic run_op(input string tag, input bit poke);
        logic [MAXE-1:0] exp_m;
        logic exp_e;
        int exp_lat, lat;
        model(exp_m, exp_e, exp_lat);
        exp_q.push_back(exp_m);
        @(negedge clk);
        check({tag, " ready"}, MAXE'(ready), MAXE'(1'b1));
        check({tag, " hold"}, mask_result, last_mask);
        apply_inputs();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 64) begin
            scramble_inputs();
            start = (poke && lat == 2);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check({tag, " latency"}, MAXE'(lat), MAXE'(exp_lat));
        check({tag, " mask"}, mask_result, exp_q.pop_front());
        check({tag, " error"}, MAXE'(error), MAXE'(exp_e));
        check({tag, " busy"}, MAXE'(ready), MAXE'(1'b0));
        last_mask = exp_m;
    endtask

    task automatic set_op(input int op, input int s, input bit opnd, input bit vmv, input int vlv);
        t_op = 3'(op); t_sew = 2'(s); t_opnd = opnd; t_vm = vmv; t_vl = VL_W'(vlv);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit saw_done;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst ready", MAXE'(ready), MAXE'(1'b1));
        check("rst done", MAXE'(done), '0);
        check("rst error", MAXE'(error), '0);
        check("rst mask", mask_result, '0);
        check("rst state", MAXE'(fsm_state), MAXE'(IDLE));

        // SEW=32 vv LT: every vs2 element is -1, rhs is 0
        set_op(4, 2, 0, 1, 16);
        t_vs2 = '1; t_vs1 = '0; t_scalar = '0; t_v0 = '0; t_vd_old = rand_mask();
        run_op("lt32", 0);
        check("lt32 low16", MAXE'(mask_result[15:0]), MAXE'(16'hFFFF));

        // SEW=8 vx GTU against 0x80 with alternating 0xFF/0x7F
        set_op(7, 0, 1, 1, 64);
        for (int i = 0; i < VLEN / 8; i++) t_vs2[i*8 +: 8] = (i % 2 == 0) ? 8'hFF : 8'h7F;
        t_scalar = 32'h1234_5680; t_vs1 = rand_vec(); t_vd_old = rand_mask();
        run_op("gtu8", 0);

        // SEW=16 vv EQ masked by v0, inactive bits keep vd_old
        set_op(0, 1, 0, 0, 16);
        t_vs2 = rand_vec(); t_vs1 = t_vs2; t_v0 = MAXE'(16'h5555); t_vd_old = '1;
        run_op("eq16", 0);

        // vl = 0, then SEW=64 (> ELEN), then vl beyond VLEN/SEW
        set_op(1, 2, 0, 1, 0);
        t_vd_old = rand_mask();
        run_op("vl0", 0);
        set_op(1, 3, 0, 1, 8);
        t_vd_old = rand_mask();
        run_op("sew64", 0);
        set_op(2, 2, 0, 1, 129);
        t_vd_old = rand_mask();
        run_op("vlmax", 0);

        // Boundary vl values; start poked mid-run; back-to-back accepts
        set_op(5, 2, 0, 1, 128);
        t_vs2 = rand_vec(); t_vs1 = rand_vec(); t_vd_old = rand_mask();
        run_op("full32", 1);
        set_op(6, 2, 1, 0, 9);
        t_scalar = $urandom; t_v0 = rand_mask();
        run_op("b2b", 0);
        set_op(3, 0, 0, 1, 1);
        run_op("vl1", 0);
        set_op(2, 0, 0, 1, 512);
        run_op("full8", 0);

        // Reset in the middle of a long run
        set_op(4, 2, 0, 1, 128);
        t_vs2 = rand_vec(); t_vs1 = rand_vec(); t_vd_old = rand_mask();
        @(negedge clk);
        apply_inputs();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid rst ready", MAXE'(ready), MAXE'(1'b1));
        check("mid rst done", MAXE'(done), '0);
        check("mid rst error", MAXE'(error), '0);
        check("mid rst mask", mask_result, '0);
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            saw_done |= done;
        end
        check("mid rst no done", MAXE'(saw_done), '0);
        last_mask = '0;
        set_op(6, 1, 0, 1, 40);
        t_vs2 = rand_vec(); t_vs1 = rand_vec(); t_vd_old = rand_mask();
        run_op("after rst", 0);

        // Random operations
        for (int n = 0; n < 24; n++) begin
            set_op($urandom_range(0, 7), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(0, MAXE) : $urandom_range(0, 40));
            t_vs2 = rand_vec();
            t_vs1 = ($urandom_range(0, 1) == 1) ? t_vs2 : rand_vec();
            t_scalar = $urandom; t_v0 = rand_mask(); t_vd_old = rand_mask();
            run_op("rand", 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vec_mask_compare_unit.md
# vec_mask_compare_unit

Multi-cycle, parametrised vector integer compare unit producing an RVV-style packed mask, with one bit per element. It supports vector-vector and vector-scalar operands, v0 masking, `vl` tail handling and a start/done handshake. Elements are processed in `DP_W`-bit beats, so area scales with datapath width rather than `VLEN`. It sits in the vector execute stage next to the combinational compare path and writes a mask register through the regfile write port.

## Interface
- `VLEN`, 4096: vector register width in bits.
- `ELEN`, 32: largest supported SEW; 8, 16, 32 or 64.
- `DP_W`, 256: bits compared per beat; power of two, ELEN ≤ DP_W ≤ VLEN.
- `MAXE`, VLEN/8 (derived): maximum element count and mask width.
- `clk` input 1: clock.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: request; accepted only when `ready`=1.
- `ready` output 1: unit idle, able to accept `start`.
- `cmp_op` input 3: EQ=000, NE=001, LTU=010, LEU=011, LT=100, LE=101, GT=110, GTU=111.
- `sew` input 2: 00=8, 01=16, 10=32, 11=64.
- `opnd_sel` input 1: 0 = vector-vector (`vs1_data`), 1 = vector-scalar (`scalar`).
- `vs2_data` input VLEN: left operand.
- `vs1_data` input VLEN: right operand in vv mode.
- `scalar` input ELEN: right operand in vx mode; low SEW bits are broadcast to every element.
- `vm` input 1: 1 = unmasked; 0 = use `v0_mask`.
- `v0_mask` input MAXE: bit i enables element i.
- `vd_old` input MAXE: prior destination mask, for undisturbed bits.
- `vl` input $clog2(MAXE)+1: active element count.
- `mask_result` output MAXE: packed result.
- `done` output 1: one-cycle pulse; `mask_result` valid from this cycle.
- `error` output 1: SEW unsupported or `vl` out of range; valid with `done`.

## Operation
- Result bit i for active element i = `vs2[i] OP rhs[i]`, where `rhs` is `vs1` or the broadcast scalar. Example: LT sets bit i when vs2 < rhs.
- Signed ops (LT, LE, GT) use two's complement at SEW width. Unsigned ops (LTU, LEU, GTU) use plain magnitude.
- Element i is active when i < `vl` and (`vm`=1 or `v0_mask[i]`=1).
  - Inactive element bits take `vd_old[i]`.
  - Tail bits (i ≥ `vl`) take `vd_old[i]`.
- All inputs are latched on accepted `start`. Input changes during RUN have no effect.
- Elements per beat: EPB = DP_W/SEW. Beats = ceil(`vl`/EPB).
  - Beat k covers elements k·EPB … k·EPB+EPB−1.
- FSM states are IDLE, RUN and DONE.
  - IDLE→RUN on `start` with valid parameters and `vl`>0.
  - IDLE→DONE on `start` with `vl`=0, or with an error condition.
  - RUN→DONE after the beat containing element `vl`−1.
  - DONE→IDLE unconditionally, after one cycle.
- Error conditions:
  - SEW > ELEN.
  - `vl` > VLEN/SEW.
  - On error: `mask_result`=`vd_old`, `error`=1, no beats executed.
- `start` while `ready`=0 is ignored; it is not queued.
- `mask_result` holds its value from DONE until the next accepted `start`.
  - In RUN, bits update per beat.
  - At accept, `mask_result` is loaded with `vd_old`.

## Timing
- Reset values: `ready`=1, `done`=0, `error`=0, `mask_result`=0. FSM goes to IDLE and the beat counter clears.
- Accept at edge t.
  - Beat k is computed during cycle t+1+k.
  - `done`=1 in cycle t+1+Beats.
  - `ready` returns to 1 in cycle t+2+Beats.
- `vl`=0 or error: `done` in cycle t+1.
- `ready`=0 from cycle t+1 through the DONE cycle.
- A `start` in the first `ready` cycle after DONE is accepted, giving back-to-back operations with one idle gap.
- Reset asserted mid-RUN aborts immediately. All outputs go to their reset values and no `done` is produced.
- Beat counter width: $clog2(VLEN/8)+1. No wrap: the FSM leaves RUN on the last beat.

## Structure
- Package `vec_cmp_pkg` holds:
  - `cmp_op_e`, `sew_e`, `opnd_sel_e` and `cmp_state_e` (IDLE/RUN/DONE).
  - A function returning SEW bit width.
- Sub-module `vec_cmp_slice` (combinational): one DP_W chunk in, DP_W/8 result bits out, all SEWs. The top module instantiates it once, and owns the FSM, operand latches, broadcast and mask merge.

## Test plan
- SEW=32, vv, LT, `vl`=16, vm=1, vs2 elements = −1, rhs = 0:
  - Bits 15:0 = 1, upper bits = `vd_old`.
  - `done` 3 cycles after accept (2 beats).
- SEW=8, vx, GTU, scalar=0x80, vs2 = 0xFF/0x7F alternating, `vl`=64:
  - Even bits 1, odd bits 0.
  - 2 beats.
- SEW=16, vv, EQ, equal operands, vm=0, v0=0x5555, `vd_old`=all 1, `vl`=16:
  - Result 0xFFFF: active bits are 1 and inactive bits keep 1.
- `vl`=0, then SEW=11 with ELEN=32:
  - `done` next cycle, `mask_result`=`vd_old`.
  - `error`=0, then `error`=1.
- `start` pulsed during RUN, then back-to-back starts:
  - Second `start` is ignored.
  - A `start` on the first `ready` cycle is accepted.
- Reset asserted mid-RUN, `vl`=128 at SEW=32:
  - All outputs return to reset values with no `done`.
  - A new op afterwards completes correctly.
